pc_gen_unit: RTL and testbench

//  Fetch-stage PC generator for the pipelined MIPS core: holds the PC register and computes next-PC.

---
 rtl/pc_gen_unit.sv | 182 ++++++++++++++++++
 tb/tb_pc_gen_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// pc_gen_unit -- fetch-stage PC generator for the pipelined MIPS core.
//
// Holds the fetch PC register and computes the next PC from one of five
// sources: sequential, taken branch, jump, jump-register, exception vector.
// Redirects are resolved in decode and take effect on the next rising edge.
// A stall holds the PC, but an exception redirect always wins.
//
// Optional feature macro: PC_GEN_RAS_EN
//   defined   -> a circular return-address stack (RAS) predicts jr $ra targets
//   undefined -> no RAS storage, oras_valid/oras_pred tie to zero and the
//                call/return hints are ignored
//
// Ports
//   iclk        clock, rising edge
//   irst_n      asynchronous reset, active low
//   istall      hold PC, block RAS push/pop
//   iNPC_sel    0 SEQ, 1 BRANCH, 2 JUMP, 3 JUMPREG, 4 EXC, 5-7 act as SEQ
//   iD_PC       PC of the decode-stage control instruction
//   iinstr      decode-stage instruction word
//   irs         forwarded GPR[rs] for JUMPREG
//   iis_call    decode instruction is jal/jalr (RAS push)
//   iis_ret     decode instruction is jr $31 (RAS pop)
//   oPC         current fetch PC (registered)
//   oNPC        next PC (combinational)
//   oPC8        iD_PC + 8, link value
//   omisalign   oPC[1:0] != 0, report only
//   oras_pred   RAS top entry, zero when empty
//   oras_valid  RAS non-empty
module pc_gen_unit #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          RAS_DEPTH = 4
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             istall,
    input  logic [2:0]       iNPC_sel,
    input  logic [WIDTH-1:0] iD_PC,
    input  logic [31:0]      iinstr,
    input  logic [WIDTH-1:0] irs,
    input  logic             iis_call,
    input  logic             iis_ret,
    output logic [WIDTH-1:0] oPC,
    output logic [WIDTH-1:0] oNPC,
    output logic [WIDTH-1:0] oPC8,
    output logic             omisalign,
    output logic [WIDTH-1:0] oras_pred,
    output logic             oras_valid
);

    localparam logic [2:0] SEL_SEQ     = 3'd0;
    localparam logic [2:0] SEL_BRANCH  = 3'd1;
    localparam logic [2:0] SEL_JUMP    = 3'd2;
    localparam logic [2:0] SEL_JUMPREG = 3'd3;
    localparam logic [2:0] SEL_EXC     = 3'd4;

    localparam logic [WIDTH-1:0] STEP4  = WIDTH'(4'd4);
    localparam logic [WIDTH-1:0] STEP8  = WIDTH'(4'd8);
    localparam logic [WIDTH-1:0] PC_RST = RESET_PC[WIDTH-1:0];
    localparam logic [WIDTH-1:0] PC_EXC = EXC_VEC[WIDTH-1:0];

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] npc_s;
    logic [WIDTH-1:0] pc8_s;
    logic [31:0]      br_off32_s;
    logic [WIDTH-1:0] br_tgt_s;
    logic [27:0]      j_field_s;
    logic [WIDTH-1:0] j_tgt_s;
    logic             is_exc_s;

    // Redirect target arithmetic shared by the next-PC mux and the link value.
    always_comb begin
        br_off32_s = {{14{iinstr[15]}}, iinstr[15:0], 2'b00};
        br_tgt_s   = iD_PC + STEP4 + br_off32_s[WIDTH-1:0];
        j_field_s  = {iinstr[25:0], 2'b00};
        // WIDTH is at least 30, so the 28-bit field always fits under the region bits.
        j_tgt_s    = {iD_PC[WIDTH-1:28], j_field_s};
        pc8_s      = iD_PC + STEP8;
        is_exc_s   = (iNPC_sel == SEL_EXC);
    end

    // Next-PC source select; undefined selector codes fall back to sequential.
    always_comb begin
        npc_s = pc_r + STEP4;
        case (iNPC_sel)
            SEL_SEQ:     npc_s = pc_r + STEP4;
            SEL_BRANCH:  npc_s = br_tgt_s;
            SEL_JUMP:    npc_s = j_tgt_s;
            SEL_JUMPREG: npc_s = irs;
            SEL_EXC:     npc_s = PC_EXC;
            default:     npc_s = pc_r + STEP4;
        endcase
    end

    // Fetch PC register: exception ignores stall, otherwise stall holds.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            pc_r <= PC_RST;
        end else if (is_exc_s) begin
            pc_r <= PC_EXC;
        end else if (!istall) begin
            pc_r <= npc_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    assign oPC       = pc_r;
    assign oNPC      = npc_s;
    assign oPC8      = pc8_s;
    assign omisalign = (pc_r[1:0] != 2'b00);

`ifdef PC_GEN_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0] tp_r;
    logic [PTR_W:0]   cnt_r;
    logic [PTR_W-1:0] tp_inc_s;
    logic [PTR_W-1:0] tp_dec_s;
    logic             ras_upd_s;
    logic             unused_s;

    // Circular pointer neighbours; RAS_DEPTH is a power of two so wrap is free.
    always_comb begin
        tp_inc_s  = tp_r + PTR_W'(1'b1);
        tp_dec_s  = tp_r - PTR_W'(1'b1);
        ras_upd_s = !istall && !is_exc_s;
    end

    // RAS state: exception flushes the count, push+pop rewrites the top in place.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            tp_r  <= '0;
            cnt_r <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_r[i] <= '0;
            end
        end else if (is_exc_s) begin
            // Entries keep stale data; a zero count hides them.
            cnt_r <= '0;
        end else if (ras_upd_s) begin
            if (iis_call && iis_ret) begin
                ras_mem_r[tp_r] <= pc8_s;
            end else if (iis_call) begin
                // On overflow the oldest entry is overwritten and the count saturates.
                ras_mem_r[tp_inc_s] <= pc8_s;
                tp_r                <= tp_inc_s;
                if (cnt_r != CNT_FULL) begin
                    cnt_r <= cnt_r + (PTR_W + 1)'(1'b1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end else if (iis_ret) begin
                if (cnt_r != '0) begin
                    tp_r  <= tp_dec_s;
                    cnt_r <= cnt_r - (PTR_W + 1)'(1'b1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign oras_valid = (cnt_r != '0);
    assign oras_pred  = (cnt_r != '0) ? ras_mem_r[tp_r] : '0;
    assign unused_s   = ^iinstr[31:26];
`else
    logic unused_s;

    assign oras_valid = 1'b0;
    assign oras_pred  = '0;
    assign unused_s   = ^{iinstr[31:26], iis_call, iis_ret};
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

    logic        iclk      = 1'b0;
    logic        irst_n    = 1'b0;
    logic        istall    = 1'b0;
    logic [2:0]  iNPC_sel  = 3'd0;
    logic [31:0] iD_PC     = 32'd0;
    logic [31:0] iinstr    = 32'd0;
    logic [31:0] irs       = 32'd0;
    logic        iis_call  = 1'b0;
    logic        iis_ret   = 1'b0;
    logic [31:0] oPC;
    logic [31:0] oNPC;
    logic [31:0] oPC8;
    logic        omisalign;
    logic [31:0] oras_pred;
    logic        oras_valid;

`ifdef PC_GEN_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif
    localparam int DEPTH = 4;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: the PC and the visible return stack as a plain queue.
    logic [31:0] m_pc = 32'h0000_3000;
    logic [31:0] m_ras[$];

    pc_gen_unit dut (
        .iclk(iclk), .irst_n(irst_n), .istall(istall), .iNPC_sel(iNPC_sel),
        .iD_PC(iD_PC), .iinstr(iinstr), .irs(irs), .iis_call(iis_call),
        .iis_ret(iis_ret), .oPC(oPC), .oNPC(oNPC), .oPC8(oPC8),
        .omisalign(omisalign), .oras_pred(oras_pred), .oras_valid(oras_valid)
    );

    always #5 iclk = ~iclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [2:0] sel,
                                            input logic [31:0] dpc, input logic [31:0] ins,
                                            input logic [31:0] rs);
        logic [31:0] off;
        off = {{16{ins[15]}}, ins[15:0]};
        case (sel)
            3'd1:    return dpc + 32'd4 + off * 32'd4;
            3'd2:    return (dpc & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
            3'd3:    return rs;
            3'd4:    return 32'h0000_4180;
            default: return pc + 32'd4;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 32'h0000_3000;
        m_ras.delete();
    endtask

    // Apply one clock edge's worth of the rules to the reference state.
    task automatic model_edge();
        logic [31:0] n;
        logic [31:0] d;
        n = ref_npc(m_pc, iNPC_sel, iD_PC, iinstr, irs);
        if (iNPC_sel == 3'd4) begin
            m_pc = 32'h0000_4180;
            m_ras.delete();
        end else if (!istall) begin
            m_pc = n;
            if (RAS_ON) begin
                if (iis_call && iis_ret) begin
                    if (m_ras.size() > 0) m_ras[m_ras.size() - 1] = iD_PC + 32'd8;
                end else if (iis_call) begin
                    m_ras.push_back(iD_PC + 32'd8);
                    if (m_ras.size() > DEPTH) d = m_ras.pop_front();
                end else if (iis_ret) begin
                    if (m_ras.size() > 0) d = m_ras.pop_back();
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge iclk);
        model_edge();
        #1;
    endtask

    // Every settled cycle: all outputs against the reference model.
    always @(negedge iclk) begin
        if (irst_n) begin
            check("pc", oPC, m_pc);
            check("npc", oNPC, ref_npc(m_pc, iNPC_sel, iD_PC, iinstr, irs));
            check("pc8", oPC8, iD_PC + 32'd8);
            check("misalign", {31'd0, omisalign}, {31'd0, m_pc[1:0] != 2'b00});
            check("ras_valid", {31'd0, oras_valid}, {31'd0, m_ras.size() > 0});
            check("ras_pred", oras_pred, (m_ras.size() > 0) ? m_ras[m_ras.size() - 1] : 32'd0);
        end
    end

    initial begin
        logic [31:0] preds [4];
        int r;
        preds[0] = 32'h3048; preds[1] = 32'h3038; preds[2] = 32'h3028; preds[3] = 32'h3018;

        #12 irst_n = 1'b1;
        #1;
        check("rst_pc", oPC, 32'h3000);
        check("rst_valid", {31'd0, oras_valid}, 32'd0);
        check("rst_pred", oras_pred, 32'd0);

        cycle(); check("seq1", oPC, 32'h3004);
        cycle(); check("seq2", oPC, 32'h3008);
        cycle(); check("seq3", oPC, 32'h300C);
        istall = 1'b1;
        cycle(); check("stall1", oPC, 32'h300C);
        cycle(); check("stall2", oPC, 32'h300C);
        istall = 1'b0;
        cycle(); check("unstall", oPC, 32'h3010);

        iNPC_sel = 3'd1; iD_PC = 32'h3010; iinstr = 32'h0000_FFFC;
        #1 check("br_npc", oNPC, 32'h3004);
        cycle(); check("br_pc", oPC, 32'h3004);

        iNPC_sel = 3'd2; iinstr = 32'h0800_0C40;
        #1 check("j_npc", oNPC, 32'h3100);
        cycle(); check("j_pc", oPC, 32'h3100);

        iNPC_sel = 3'd3; irs = 32'h3402;
        cycle(); check("jr_pc", oPC, 32'h3402);
        check("jr_misalign", {31'd0, omisalign}, 32'd1);
        iNPC_sel = 3'd0;

        for (int i = 0; i < 5; i++) begin
            iis_call = 1'b1; iD_PC = 32'h3000 + 32'h10 * i;
            cycle();
        end
        iis_call = 1'b0; iis_ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ras_pop_pred", oras_pred, RAS_ON ? preds[i] : 32'd0);
            check("ras_pop_valid", {31'd0, oras_valid}, {31'd0, RAS_ON});
            cycle();
        end
        check("ras_empty", {31'd0, oras_valid}, 32'd0);
        cycle();
        check("ras_5th_pop", {31'd0, oras_valid}, 32'd0);
        check("ras_5th_pred", oras_pred, 32'd0);
        iis_ret = 1'b0;

        iis_call = 1'b1; iD_PC = 32'h3100;
        cycle();
        check("ras_refill", {31'd0, oras_valid}, {31'd0, RAS_ON});
        istall = 1'b1; iNPC_sel = 3'd4;
        cycle();
        check("exc_pc", oPC, 32'h4180);
        check("exc_flush", {31'd0, oras_valid}, 32'd0);
        istall = 1'b0; iNPC_sel = 3'd0; iis_call = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            cycle();
            r        = $urandom_range(0, 15);
            iNPC_sel = (r < 9) ? 3'd0 : (r == 15) ? 3'd4 : 3'(r - 8);
            istall   = ($urandom_range(0, 3) == 0);
            iD_PC    = $urandom;
            iinstr   = $urandom;
            irs      = $urandom;
            iis_call = ($urandom_range(0, 4) < 2);
            iis_ret  = ($urandom_range(0, 4) < 2);
            if (n == 1500) begin
                #2 irst_n = 1'b0;
                model_reset();
                #1;
                check("async_rst_pc", oPC, 32'h3000);
                check("async_rst_valid", {31'd0, oras_valid}, 32'd0);
                #4 irst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
